// File: rtl/am_pkg.sv
// 6502 addressing-mode codes, sequencer state encoding
// and the zero-page address helper.
package am_pkg;

  typedef enum logic [3:0] {
    AM_IMM  = 4'd0,
    AM_ZP   = 4'd1,
    AM_ZPX  = 4'd2,
    AM_ZPY  = 4'd3,
    AM_ABS  = 4'd4,
    AM_ABSX = 4'd5,
    AM_ABSY = 4'd6,
    AM_INDX = 4'd7,
    AM_INDY = 4'd8,
    AM_IND  = 4'd9
  } am_e;

  localparam logic [3:0] AM_LAST = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_OP0  = 4'd1,
    S_OP1  = 4'd2,
    S_OP2  = 4'd3,
    S_PTR0 = 4'd4,
    S_PTR1 = 4'd5,
    S_PTR2 = 4'd6,
    S_FIX  = 4'd7,
    S_DONE = 4'd8
  } state_e;

  function automatic logic [15:0] zp_addr(
    input logic [7:0] base,
    input logic [7:0] lo
  );
    return {base, lo};
  endfunction

endpackage

// File: rtl/idx_add8.sv
// 8-bit adder with carry in/out, shared by index adds,
// pointer increments and the page fix-up.
module idx_add8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       ci_i,
  output logic [7:0] sum_o,
  output logic       co_o
);

  assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'b0, ci_i};

endmodule

// File: rtl/addr_seq.sv
// 6502 effective-address sequencer: fetches operand and
// pointer bytes, indexes, and reports one ea per request.
module addr_seq
  import am_pkg::*;
#(
  parameter bit         PAGE_PENALTY = 1'b1,
  parameter bit         JMP_IND_BUG  = 1'b1,
  parameter logic [7:0] ZP_BASE      = 8'h00
) (
  input  logic        CLK,
  input  logic        R_N,
  input  logic        start,
  input  logic [3:0]  mode,
  input  logic        wr_access,
  input  logic [7:0]  reg_x,
  input  logic [7:0]  reg_y,
  input  logic [15:0] pc,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        pc_inc,
  output logic        busy,
  output logic        ea_valid,
  output logic [15:0] ea,
  output logic        page_cross,
  output logic        err
);

  state_e      state_q, state_d;
  logic [3:0]  mode_q, mode_d;
  logic [7:0]  idx_q, idx_d;
  logic        wr_q, wr_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  dlo_q, dlo_d;
  logic        c_q, c_d;
  logic        err_q, err_d;
  logic [15:0] ea_q, ea_d;
  logic        pcr_q, pcr_d;

  logic [7:0] la, lb, lsum;
  logic       lci, lco;
  logic [7:0] ha, hsum;
  logic       hci, hco_unused;
  logic [7:0] ptr_hi;
  logic       indexed;

  idx_add8 u_lo (
    .a_i  (la),
    .b_i  (lb),
    .ci_i (lci),
    .sum_o(lsum),
    .co_o (lco)
  );

  idx_add8 u_hi (
    .a_i  (ha),
    .b_i  (8'h00),
    .ci_i (hci),
    .sum_o(hsum),
    .co_o (hco_unused)
  );

  assign ptr_hi  = (mode_q == AM_IND) ? hi_q : ZP_BASE;
  assign indexed = mode_q inside {AM_ABSX, AM_ABSY, AM_INDY};

  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      state_q <= S_IDLE;
      mode_q  <= 4'd0;
      idx_q   <= 8'd0;
      wr_q    <= 1'b0;
      pc_q    <= 16'd0;
      lo_q    <= 8'd0;
      hi_q    <= 8'd0;
      dlo_q   <= 8'd0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
      ea_q    <= 16'd0;
      pcr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      pc_q    <= pc_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dlo_q   <= dlo_d;
      c_q     <= c_d;
      err_q   <= err_d;
      ea_q    <= ea_d;
      pcr_q   <= pcr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    pc_d     = pc_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dlo_d    = dlo_q;
    c_d      = c_q;
    err_d    = err_q;
    ea_d     = ea_q;
    pcr_d    = pcr_q;
    la       = lo_q;
    lb       = 8'h00;
    lci      = 1'b0;
    ha       = hi_q;
    hci      = 1'b0;
    mem_addr = 16'd0;
    mem_rd   = 1'b0;
    pc_inc   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          mode_d = mode;
          wr_d   = wr_access;
          pc_d   = pc;
          err_d  = 1'b0;
          case (mode)
            AM_ZPX, AM_ABSX, AM_INDX: idx_d = reg_x;
            AM_ZPY, AM_ABSY, AM_INDY: idx_d = reg_y;
            default:                  idx_d = 8'h00;
          endcase
          unique case (1'b1)
            (mode > AM_LAST): begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
            (mode == AM_IMM): begin
              ea_d    = pc;
              pcr_d   = 1'b0;
              state_d = S_DONE;
            end
            default: state_d = S_OP0;
          endcase
        end
      end
      S_OP0: begin
        mem_addr = pc_q;
        mem_rd   = 1'b1;
        pc_inc   = 1'b1;
        state_d  = S_OP1;
      end
      S_OP1: begin
        la   = mem_rdata;
        lb   = (mode_q == AM_INDY) ? 8'h00 : idx_q;
        lo_d = lsum;
        c_d  = lco;
        case (mode_q)
          AM_ZP, AM_ZPX, AM_ZPY: begin
            ea_d    = zp_addr(ZP_BASE, lsum);
            pcr_d   = 1'b0;
            state_d = S_DONE;
          end
          AM_INDX, AM_INDY: state_d = S_PTR0;
          default: begin
            mem_addr = pc_q + 16'd1;
            mem_rd   = 1'b1;
            pc_inc   = 1'b1;
            state_d  = S_OP2;
          end
        endcase
      end
      S_OP2: begin
        hi_d = mem_rdata;
        ha   = mem_rdata;
        hci  = c_q;
        if (mode_q == AM_IND) begin
          state_d = S_PTR0;
        end else if (indexed && ((c_q && PAGE_PENALTY) || wr_q)) begin
          state_d = S_FIX;
        end else begin
          ea_d    = {hsum, lo_q};
          pcr_d   = c_q;
          state_d = S_DONE;
        end
      end
      S_PTR0: begin
        mem_addr = {ptr_hi, lo_q};
        mem_rd   = 1'b1;
        state_d  = S_PTR1;
      end
      S_PTR1: begin
        dlo_d = mem_rdata;
        la    = lo_q;
        lci   = 1'b1;
        ha    = hi_q;
        hci   = lco;
        // NMOS JMP (abs) keeps the pointer high byte fixed
        if (mode_q == AM_IND && !JMP_IND_BUG)
          mem_addr = {hsum, lsum};
        else
          mem_addr = {ptr_hi, lsum};
        mem_rd  = 1'b1;
        state_d = S_PTR2;
      end
      S_PTR2: begin
        hi_d = mem_rdata;
        if (mode_q == AM_INDY) begin
          la   = dlo_q;
          lb   = idx_q;
          lo_d = lsum;
          c_d  = lco;
          ha   = mem_rdata;
          hci  = lco;
          if ((lco && PAGE_PENALTY) || wr_q) begin
            state_d = S_FIX;
          end else begin
            ea_d    = {hsum, lsum};
            pcr_d   = lco;
            state_d = S_DONE;
          end
        end else begin
          ea_d    = {mem_rdata, dlo_q};
          pcr_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_FIX: begin
        ha      = hi_q;
        hci     = c_q;
        ea_d    = {hsum, lo_q};
        pcr_d   = c_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign ea_valid   = (state_q == S_DONE) && !err_q;
  assign err        = (state_q == S_DONE) && err_q;
  assign ea         = ea_q;
  assign page_cross = pcr_q;

endmodule

// File: tb/tb_addr_seq.sv
// Directed bench for addr_seq: d1 uses default parameters,
// d2 has no page penalty and the corrected JMP (abs) fetch.
module tb_addr_seq;
  import am_pkg::*;

  logic CLK = 1'b0;
  logic R_N = 1'b0;
  always #5 CLK = ~CLK;

  logic        start = 1'b0;
  logic [3:0]  mode = 4'd0;
  logic        wr_access = 1'b0;
  logic [7:0]  reg_x = 8'd0;
  logic [7:0]  reg_y = 8'd0;
  logic [15:0] pc = 16'd0;

  logic [15:0] addr1, addr2, ea1, ea2;
  logic        rd1, rd2, inc1, inc2, busy1, busy2;
  logic        v1, v2, pcr1, pcr2, err1, err2;
  logic [7:0]  rdata1, rdata2;

  logic [7:0] mem [0:65535];

  addr_seq d1 (
    .CLK(CLK), .R_N(R_N), .start(start), .mode(mode),
    .wr_access(wr_access), .reg_x(reg_x), .reg_y(reg_y),
    .pc(pc), .mem_addr(addr1), .mem_rd(rd1),
    .mem_rdata(rdata1), .pc_inc(inc1), .busy(busy1),
    .ea_valid(v1), .ea(ea1), .page_cross(pcr1), .err(err1)
  );

  addr_seq #(
    .PAGE_PENALTY(1'b0), .JMP_IND_BUG(1'b0), .ZP_BASE(8'h00)
  ) d2 (
    .CLK(CLK), .R_N(R_N), .start(start), .mode(mode),
    .wr_access(wr_access), .reg_x(reg_x), .reg_y(reg_y),
    .pc(pc), .mem_addr(addr2), .mem_rd(rd2),
    .mem_rdata(rdata2), .pc_inc(inc2), .busy(busy2),
    .ea_valid(v2), .ea(ea2), .page_cross(pcr2), .err(err2)
  );

  always @(posedge CLK) begin
    if (rd1) rdata1 <= mem[addr1];
    if (rd2) rdata2 <= mem[addr2];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge where
  // both DUTs have finished (or after 20 cycles, latency 0).
  task automatic run(input logic [3:0] m,
                     input logic [7:0] x, input logic [7:0] y,
                     input logic [15:0] p, input logic w,
                     output int l1, output int l2,
                     output int ninc, output int nrd);
    l1 = 0; l2 = 0; ninc = 0; nrd = 0;
    mode = m; reg_x = x; reg_y = y; pc = p;
    wr_access = w; start = 1'b1;
    for (int k = 1; k <= 20 && (l1 == 0 || l2 == 0); k++) begin
      @(negedge CLK);
      start = 1'b0;
      if (l1 == 0) begin
        ninc += int'(inc1);
        nrd  += int'(rd1);
        if (v1 || err1) l1 = k;
      end
      if (l2 == 0 && (v2 || err2)) l2 = k;
    end
  endtask

  typedef struct {
    logic [3:0]  m;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] pc;
    logic        w;
    logic [15:0] ea;
    logic        pcr;
    int          lat;
    int          ninc;
    int          nrd;
    logic [15:0] ea2;
    int          lat2;
  } vec_t;

  vec_t vt [16];

  initial begin
    int l1, l2, ni, nr;

    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0200] = 8'hF0;
    mem[16'h0300] = 8'h80; mem[16'h0301] = 8'h12;
    mem[16'h0400] = 8'hFF;
    mem[16'h00FF] = 8'h10; mem[16'h0000] = 8'h20;
    mem[16'h0500] = 8'hFF; mem[16'h0501] = 8'h30;
    mem[16'h30FF] = 8'h40; mem[16'h3000] = 8'h50;
    mem[16'h3100] = 8'h60;
    mem[16'h0600] = 8'hFE;
    mem[16'h0001] = 8'h34; mem[16'h0002] = 8'h12;
    mem[16'h0700] = 8'h80; mem[16'h0701] = 8'hFF;

    vt[0]  = '{AM_ZPX,  8'h20, 8'h00, 16'h0200, 1'b0,
               16'h0010, 1'b0, 3, 1, 1, 16'h0010, 3};
    vt[1]  = '{AM_ZP,   8'h00, 8'h00, 16'h0200, 1'b0,
               16'h00F0, 1'b0, 3, 1, 1, 16'h00F0, 3};
    vt[2]  = '{AM_ZPY,  8'h00, 8'h05, 16'h0200, 1'b0,
               16'h00F5, 1'b0, 3, 1, 1, 16'h00F5, 3};
    vt[3]  = '{AM_ABS,  8'h00, 8'h00, 16'h0300, 1'b0,
               16'h1280, 1'b0, 4, 2, 2, 16'h1280, 4};
    vt[4]  = '{AM_ABSX, 8'h01, 8'h00, 16'h0300, 1'b0,
               16'h1281, 1'b0, 4, 2, 2, 16'h1281, 4};
    vt[5]  = '{AM_ABSX, 8'hFF, 8'h00, 16'h0300, 1'b0,
               16'h137F, 1'b1, 5, 2, 2, 16'h137F, 4};
    vt[6]  = '{AM_ABSX, 8'h01, 8'h00, 16'h0300, 1'b1,
               16'h1281, 1'b0, 5, 2, 2, 16'h1281, 5};
    vt[7]  = '{AM_ABSY, 8'h00, 8'hFF, 16'h0300, 1'b0,
               16'h137F, 1'b1, 5, 2, 2, 16'h137F, 4};
    vt[8]  = '{AM_ABSX, 8'h90, 8'h00, 16'h0700, 1'b0,
               16'h0010, 1'b1, 5, 2, 2, 16'h0010, 4};
    vt[9]  = '{AM_INDX, 8'h03, 8'h00, 16'h0600, 1'b0,
               16'h1234, 1'b0, 6, 1, 3, 16'h1234, 6};
    vt[10] = '{AM_INDX, 8'h01, 8'h00, 16'h0600, 1'b0,
               16'h2010, 1'b0, 6, 1, 3, 16'h2010, 6};
    vt[11] = '{AM_INDY, 8'h00, 8'hF0, 16'h0400, 1'b0,
               16'h2100, 1'b1, 7, 1, 3, 16'h2100, 6};
    vt[12] = '{AM_INDY, 8'h00, 8'h05, 16'h0400, 1'b0,
               16'h2015, 1'b0, 6, 1, 3, 16'h2015, 6};
    vt[13] = '{AM_INDY, 8'h00, 8'h05, 16'h0400, 1'b1,
               16'h2015, 1'b0, 7, 1, 3, 16'h2015, 7};
    vt[14] = '{AM_IND,  8'h00, 8'h00, 16'h0500, 1'b0,
               16'h5040, 1'b0, 7, 2, 4, 16'h6040, 7};
    vt[15] = '{AM_IMM,  8'h00, 8'h00, 16'hABCD, 1'b0,
               16'hABCD, 1'b0, 1, 0, 0, 16'hABCD, 1};

    // reset state
    @(negedge CLK);
    chk("rst_flags", {busy1, v1, err1, rd1, inc1, pcr1}, 64'd0);
    chk("rst_addr", addr1, 64'd0);
    chk("rst_ea", ea1, 64'd0);
    R_N = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 16; i++) begin
      run(vt[i].m, vt[i].x, vt[i].y, vt[i].pc, vt[i].w,
          l1, l2, ni, nr);
      chk($sformatf("v%0d_lat", i), l1, vt[i].lat);
      chk($sformatf("v%0d_ea", i), ea1, vt[i].ea);
      chk($sformatf("v%0d_pcross", i), pcr1, vt[i].pcr);
      chk($sformatf("v%0d_pcinc", i), ni, vt[i].ninc);
      chk($sformatf("v%0d_rd", i), nr, vt[i].nrd);
      chk($sformatf("v%0d_lat2", i), l2, vt[i].lat2);
      chk($sformatf("v%0d_ea2", i), ea2, vt[i].ea2);
      @(negedge CLK);
    end

    // reset asserted in PTR1 of an INDX request
    mode = AM_INDX; reg_x = 8'h03; pc = 16'h0600;
    wr_access = 1'b0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    chk("ptr1_rd", {rd1, busy1, addr1}, {2'b11, 16'h0002});
    R_N = 1'b0;
    #1;
    chk("midrst_flags", {busy1, v1, err1, rd1, inc1, pcr1}, 64'd0);
    chk("midrst_addr", addr1, 64'd0);
    chk("midrst_ea", ea1, 64'd0);
    @(negedge CLK);
    R_N = 1'b1;
    @(negedge CLK);
    run(AM_IMM, 8'h00, 8'h00, 16'hC000, 1'b0, l1, l2, ni, nr);
    chk("imm_after_rst_lat", l1, 64'd1);
    chk("imm_after_rst_ea", ea1, 64'hC000);
    @(negedge CLK);

    // illegal mode keeps ea/page_cross
    run(AM_ABSX, 8'hFF, 8'h00, 16'h0300, 1'b0, l1, l2, ni, nr);
    @(negedge CLK);
    run(4'hC, 8'h00, 8'h00, 16'h1234, 1'b0, l1, l2, ni, nr);
    chk("ill_lat", l1, 64'd1);
    chk("ill_pulse", {err1, v1, busy1}, {3'b100});
    chk("ill_ea_held", {pcr1, ea1}, {1'b1, 16'h137F});
    chk("ill_no_rd", nr, 64'd0);
    @(negedge CLK);
    chk("ill_err_clear", err1, 64'd0);

    // start while busy ignored
    mode = AM_ABS; pc = 16'h0300; start = 1'b1;
    @(negedge CLK);
    mode = AM_IMM; pc = 16'h1111;
    @(negedge CLK);
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    chk("busy_ign_ea", {v1, ea1}, {1'b1, 16'h1280});
    @(negedge CLK);
    chk("busy_ign_idle", {v1, busy1, ea1}, {2'b00, 16'h1280});

    // back-to-back request from DONE
    run(AM_ZP, 8'h00, 8'h00, 16'h0200, 1'b0, l1, l2, ni, nr);
    chk("b2b_first", {v1, ea1}, {1'b1, 16'h00F0});
    mode = AM_IMM; pc = 16'h2222; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("b2b_second", {v1, busy1, ea1}, {2'b10, 16'h2222});
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
